// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: sequencer state encoding and default byte width.
package uart_pkg;

    localparam int WIDTH_DEF = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_WAIT  = 3'd2,
        S_CAPT  = 3'd3,
        S_RECOV = 3'd4
    } rx_state_e;

endpackage

// File: rtl/uart_rx_fifo.sv
// Small circular RX FIFO, DEPTH x WIDTH, first-word fall-through head; pop frees a slot before push.
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      level
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             pop_ok;
    logic             push_ok;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    // Head is gated so the port reads zero whenever nothing is stored.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop_ok)
                rd_ptr <= rd_ptr + AW'(1);
            level <= level + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: arms the receiver on a start bit, captures its byte into the RX FIFO, recovers hung frames.
// Optional idle-timeout interrupt is built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int DEPTH      = 4,
    parameter int AW         = 2,
    parameter int WDOG_TICKS = 12
`ifdef UART_RX_TIMEOUT_EN
   ,parameter int IDLE_TICKS = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             baud_tick,
    input  logic             ctrl_en,
    input  logic             rx_line,
    input  logic             rx_busy,
    input  logic             rx_done,
    input  logic [WIDTH-1:0] rx_byte,
    output logic             rx_en,
    output logic             rx_rst,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      level,
    output logic             overrun,
    output logic             frame_err,
`ifdef UART_RX_TIMEOUT_EN
    output logic             timeout,
`endif
    input  logic             clr_err,
    output logic             irq
);

    localparam int WW = $clog2(WDOG_TICKS + 1);

    rx_state_e       state, state_nx;
    logic [WW-1:0]   wdog;
    logic            cap_push;
    logic            ovr_set;
    logic            ferr_set;

    uart_rx_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cap_push),
        .wdata (rx_byte),
        .pop   (rd_en),
        .rdata (rd_data),
        .empty (empty),
        .full  (full),
        .level (level)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wdog      <= '0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == S_RECOV)
                wdog <= '0;
            else if (state == S_WAIT && baud_tick && wdog != WW'(WDOG_TICKS))
                wdog <= wdog + WW'(1);
            overrun   <= ovr_set  | (overrun   & ~clr_err);
            frame_err <= ferr_set | (frame_err & ~clr_err);
        end
    end

    always_comb begin
        state_nx = state;
        rx_en    = 1'b0;
        rx_rst   = 1'b0;
        cap_push = 1'b0;
        ovr_set  = 1'b0;
        ferr_set = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (ctrl_en && !rx_line && baud_tick)
                    state_nx = S_ARM;
            end
            S_ARM: begin
                rx_en = 1'b1;
                if (!ctrl_en)
                    state_nx = S_RECOV;
                else if (rx_busy)
                    state_nx = S_WAIT;
            end
            S_WAIT: begin
                rx_en = 1'b1;
                // Software disable abandons the frame without capturing it.
                if (!ctrl_en)
                    state_nx = S_RECOV;
                else if (rx_done)
                    state_nx = S_CAPT;
                else if (wdog == WW'(WDOG_TICKS)) begin
                    ferr_set = 1'b1;
                    state_nx = S_RECOV;
                end
            end
            S_CAPT: begin
                cap_push = 1'b1;
                // A same-cycle pop frees the slot, so only a pop-less full drops the byte.
                ovr_set  = full & ~rd_en;
                state_nx = S_RECOV;
            end
            S_RECOV: begin
                rx_rst   = 1'b1;
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

`ifdef UART_RX_TIMEOUT_EN
    localparam int IW = $clog2(IDLE_TICKS + 1);

    logic [IW-1:0] idle_cnt;
    logic          to_set;

    assign to_set = (state == S_IDLE) && !empty && baud_tick && (idle_cnt == IW'(IDLE_TICKS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idle_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            if (cap_push || state != S_IDLE || empty)
                idle_cnt <= '0;
            else if (baud_tick && idle_cnt != IW'(IDLE_TICKS))
                idle_cnt <= idle_cnt + IW'(1);
            timeout <= to_set | (timeout & ~clr_err & ~(rd_en & ~empty));
        end
    end

    assign irq = ~empty | overrun | frame_err | timeout;
`else
    assign irq = ~empty | overrun | frame_err;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: queue-based FIFO/status model checked every cycle, directed and random frames.
module tb_uart_rx_ctrl;
    localparam int DEPTH = 4;
    localparam int WDOG  = 12;

    logic       clk = 1'b0;
    logic       rst_n, baud_tick, ctrl_en, rx_line, rx_busy, rx_done;
    logic [7:0] rx_byte;
    logic       rx_en, rx_rst, rd_en;
    logic [7:0] rd_data;
    logic       empty, full;
    logic [2:0] level;
    logic       overrun, frame_err, clr_err, irq;
`ifdef UART_RX_TIMEOUT_EN
    logic       timeout;
`endif

    uart_rx_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .baud_tick (baud_tick),
        .ctrl_en   (ctrl_en),
        .rx_line   (rx_line),
        .rx_busy   (rx_busy),
        .rx_done   (rx_done),
        .rx_byte   (rx_byte),
        .rx_en     (rx_en),
        .rx_rst    (rx_rst),
        .rd_en     (rd_en),
        .rd_data   (rd_data),
        .empty     (empty),
        .full      (full),
        .level     (level),
        .overrun   (overrun),
        .frame_err (frame_err),
`ifdef UART_RX_TIMEOUT_EN
        .timeout   (timeout),
`endif
        .clr_err   (clr_err),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   fails  = 0;
    bit   chk_on = 0;
    bit   rand_on = 0;
    bit   exp_push = 0;
    bit   exp_ferr = 0;

    logic [7:0] q[$];
    bit         m_ovr = 0;
    bit         m_ferr = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a byte queue plus two sticky flags, advanced at each active edge.
    initial begin
        bit ovr_set;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                q.delete();
                m_ovr  = 0;
                m_ferr = 0;
            end else begin
                ovr_set = 0;
                if (rd_en && q.size() != 0) void'(q.pop_front());
                if (exp_push) begin
                    if (q.size() < DEPTH) q.push_back(rx_byte);
                    else ovr_set = 1;
                end
                m_ovr  = ovr_set  | (m_ovr  & ~clr_err);
                m_ferr = exp_ferr | (m_ferr & ~clr_err);
            end
        end
    end

    initial begin
        logic irq_exp;
        forever begin
            @(negedge clk);
            if (chk_on) begin
                irq_exp = (q.size() != 0) | m_ovr | m_ferr;
`ifdef UART_RX_TIMEOUT_EN
                irq_exp = irq_exp | timeout;
`endif
                chk("level", 32'(level), 32'(q.size()));
                chk("empty", 32'(empty), 32'(q.size() == 0));
                chk("full", 32'(full), 32'(q.size() == DEPTH));
                if (q.size() != 0) chk("rd_data", 32'(rd_data), 32'(q[0]));
                chk("overrun", 32'(overrun), 32'(m_ovr));
                chk("frame_err", 32'(frame_err), 32'(m_ferr));
                chk("irq", 32'(irq), 32'(irq_exp));
            end
        end
    end

    task automatic step();
        @(negedge clk);
        if (rand_on) begin
            rd_en   = ($urandom_range(3, 0) == 0);
            clr_err = ($urandom_range(15, 0) == 0);
        end
    endtask

    task automatic start_frame();
        rx_line = 1'b0; baud_tick = 1'b1; step();
        rx_line = 1'b1; baud_tick = 1'b0;
        chk("rx_en_arm", 32'(rx_en), 32'd1);
        rx_busy = 1'b1; step();
        chk("rx_en_wait", 32'(rx_en), 32'd1);
    endtask

    task automatic finish_ok(input logic [7:0] b, input bit pop_capt);
        int pre;
        pre = $urandom_range(6, 0);
        for (int i = 0; i < pre; i++) begin
            baud_tick = 1'($urandom_range(1, 0)); step();
        end
        baud_tick = 1'b0; rx_done = 1'b1; rx_byte = b; step();
        chk("rx_rst_capt", 32'(rx_rst), 32'd0);
        exp_push = 1;
        if (pop_capt) rd_en = 1'b1;
        step();
        exp_push = 0;
        if (pop_capt) rd_en = 1'b0;
        chk("rx_rst_pulse", 32'(rx_rst), 32'd1);
        chk("rx_en_recov", 32'(rx_en), 32'd0);
        rx_done = 1'b0; rx_busy = 1'b0; step();
        chk("rx_rst_end", 32'(rx_rst), 32'd0);
    endtask

    task automatic finish_ferr();
        for (int i = 0; i < WDOG; i++) begin
            baud_tick = 1'b1; step();
        end
        baud_tick = 1'b0;
        chk("wdog_not_early", 32'(rx_en), 32'd1);
        exp_ferr = 1; step();
        exp_ferr = 0;
        chk("rx_rst_wdog", 32'(rx_rst), 32'd1);
        rx_busy = 1'b0; step();
        chk("rx_rst_wdog_end", 32'(rx_rst), 32'd0);
    endtask

    task automatic pop_chk(input string nm, input logic [7:0] exp);
        chk(nm, 32'(rd_data), 32'(exp));
        rd_en = 1'b1; step(); rd_en = 1'b0;
    endtask

    task automatic chk_reset_vals(input string nm);
        chk({nm, "_empty"}, 32'(empty), 32'd1);
        chk({nm, "_full"}, 32'(full), 32'd0);
        chk({nm, "_level"}, 32'(level), 32'd0);
        chk({nm, "_rd_data"}, 32'(rd_data), 32'd0);
        chk({nm, "_ovr"}, 32'(overrun), 32'd0);
        chk({nm, "_ferr"}, 32'(frame_err), 32'd0);
        chk({nm, "_irq"}, 32'(irq), 32'd0);
        chk({nm, "_rx_en"}, 32'(rx_en), 32'd0);
        chk({nm, "_rx_rst"}, 32'(rx_rst), 32'd0);
    endtask

    initial begin
        rst_n = 1'b0; baud_tick = 1'b0; ctrl_en = 1'b1; rx_line = 1'b1;
        rx_busy = 1'b0; rx_done = 1'b0; rx_byte = 8'h00; rd_en = 1'b0; clr_err = 1'b0;
        step(); step();
        chk_on = 1;
        chk_reset_vals("reset");
        rst_n = 1'b1; step();

        // Single byte
        start_frame(); finish_ok(8'hA5, 0);
        chk("a5_data", 32'(rd_data), 32'hA5);
        chk("a5_level", 32'(level), 32'd1);
        chk("a5_irq", 32'(irq), 32'd1);
        pop_chk("a5_pop", 8'hA5);
        chk("a5_empty", 32'(empty), 32'd1);

        // Software disable while armed abandons the frame
        rx_line = 1'b0; baud_tick = 1'b1; step();
        rx_line = 1'b1; baud_tick = 1'b0; ctrl_en = 1'b0; step();
        chk("dis_rx_rst", 32'(rx_rst), 32'd1);
        ctrl_en = 1'b1; step();
        chk("dis_level", 32'(level), 32'd0);

        // Fill, overflow, ordered drain
        for (int i = 1; i <= 4; i++) begin start_frame(); finish_ok(8'(i), 0); end
        chk("fill_full", 32'(full), 32'd1);
        start_frame(); finish_ok(8'h05, 0);
        chk("ovr_set", 32'(overrun), 32'd1);
        chk("ovr_level", 32'(level), 32'd4);
        for (int i = 1; i <= 4; i++) pop_chk("drain_order", 8'(i));
        clr_err = 1'b1; step(); clr_err = 1'b0;
        chk("ovr_clr", 32'(overrun), 32'd0);

        // Push and pop together on a full FIFO
        for (int i = 0; i < 4; i++) begin start_frame(); finish_ok(8'h10 + 8'(i), 0); end
        start_frame(); finish_ok(8'h14, 1);
        chk("pp_no_ovr", 32'(overrun), 32'd0);
        chk("pp_level", 32'(level), 32'd4);
        for (int i = 1; i <= 4; i++) pop_chk("pp_order", 8'h10 + 8'(i));

        // Watchdog
        start_frame(); finish_ferr();
        chk("ferr_set", 32'(frame_err), 32'd1);
        chk("ferr_irq", 32'(irq), 32'd1);
        clr_err = 1'b1; step(); clr_err = 1'b0;
        chk("ferr_clr", 32'(frame_err), 32'd0);

        // Reset mid-frame with two bytes stored
        start_frame(); finish_ok(8'h21, 0);
        start_frame(); finish_ok(8'h22, 0);
        chk("pre_rst_level", 32'(level), 32'd2);
        start_frame();
        rst_n = 1'b0; step();
        chk_reset_vals("wait_rst");
        rst_n = 1'b1; rx_busy = 1'b0; step();

`ifdef UART_RX_TIMEOUT_EN
        start_frame(); finish_ok(8'h33, 0);
        for (int i = 0; i < 32; i++) begin baud_tick = 1'b1; step(); end
        baud_tick = 1'b0; step();
        chk("to_set", 32'(timeout), 32'd1);
        chk("to_irq", 32'(irq), 32'd1);
        rd_en = 1'b1; step(); rd_en = 1'b0;
        chk("to_clr", 32'(timeout), 32'd0);
`endif

        // Random frames with random pops and error clears
        rand_on = 1;
        for (int n = 0; n < 40; n++) begin
            int gap;
            gap = $urandom_range(3, 0);
            for (int g = 0; g < gap; g++) begin baud_tick = 1'($urandom_range(1, 0)); step(); end
            baud_tick = 1'b0;
            start_frame();
            if ($urandom_range(7, 0) == 0) finish_ferr();
            else finish_ok(8'($urandom_range(255, 0)), 0);
        end
        rand_on = 0; rd_en = 1'b0; clr_err = 1'b0; step();
        for (int i = 0; i < DEPTH + 1; i++) begin rd_en = 1'b1; step(); end
        rd_en = 1'b0; step();
        chk("final_empty", 32'(empty), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
